// File: rtl/contador_hms_if.sv
// Bus between the clock divider / setting logic and the contador_hms time-of-day counter.
// The master drives the tick, run and load controls; the slave returns the BCD time, pulses and load status.
interface contador_hms_if;
  logic       tick_in;
  logic       run_en;
  logic       load_req;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic [7:0] set_ss;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic       sec_pulse;
  logic       min_pulse;
  logic       day_pulse;
  logic       load_err;

  modport master (
    output tick_in, run_en, load_req, set_hh, set_mm, set_ss,
    input  hh_bcd, mm_bcd, ss_bcd, sec_pulse, min_pulse, day_pulse, load_err
  );

  modport slave (
    input  tick_in, run_en, load_req, set_hh, set_mm, set_ss,
    output hh_bcd, mm_bcd, ss_bcd, sec_pulse, min_pulse, day_pulse, load_err
  );
endinterface

// File: rtl/contador_hms.sv
// Packed-BCD hh:mm:ss time-of-day counter advanced by divider ticks through a prescaler.
// Supports a validated time load with a sticky rejection flag.
module contador_hms #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic           clk_in,
  input  logic           rst,
  contador_hms_if.slave  bus
);

  localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_SEC - 1);

  logic [7:0] hh_q, hh_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic [7:0] pre_q, pre_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       min_pulse_q, min_pulse_d;
  logic       day_pulse_q, day_pulse_d;
  logic       load_err_q, load_err_d;
  logic       accept_s;
  logic       load_ok_s;

  // Both digits must be decimal; with that guaranteed, BCD compares like binary.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign accept_s  = bus.tick_in & bus.run_en & ~bus.load_req;
  assign load_ok_s = bcd_ok(bus.set_hh, 8'h23) & bcd_ok(bus.set_mm, 8'h59) &
                     bcd_ok(bus.set_ss, 8'h59);

  // Next-state: load has priority over ticks; a tick coincident with a load is dropped.
  always_comb begin
    hh_d        = hh_q;
    mm_d        = mm_q;
    ss_d        = ss_q;
    pre_d       = pre_q;
    load_err_d  = load_err_q;
    sec_pulse_d = 1'b0;
    min_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    if (bus.load_req) begin
      if (load_ok_s) begin
        hh_d       = bus.set_hh;
        mm_d       = bus.set_mm;
        ss_d       = bus.set_ss;
        pre_d      = 8'd0;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (accept_s) begin
      if (pre_q >= PRE_MAX) begin
        pre_d       = 8'd0;
        sec_pulse_d = 1'b1;
        if (ss_q == 8'h59) begin
          ss_d        = 8'h00;
          min_pulse_d = 1'b1;
          if (mm_q == 8'h59) begin
            mm_d = 8'h00;
            // Hours wrap at 23 rather than at a digit boundary.
            if (hh_q == 8'h23) begin
              hh_d        = 8'h00;
              day_pulse_d = 1'b1;
            end else begin
              hh_d = bcd_inc(hh_q);
            end
          end else begin
            mm_d = bcd_inc(mm_q);
          end
        end else begin
          ss_d = bcd_inc(ss_q);
        end
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end else begin
      pre_d = pre_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hh_q        <= 8'h00;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      pre_q       <= 8'd0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      pre_q       <= pre_d;
      sec_pulse_q <= sec_pulse_d;
      min_pulse_q <= min_pulse_d;
      day_pulse_q <= day_pulse_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.hh_bcd    = hh_q;
  assign bus.mm_bcd    = mm_q;
  assign bus.ss_bcd    = ss_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.min_pulse = min_pulse_q;
  assign bus.day_pulse = day_pulse_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_contador_hms.sv
// Bench for contador_hms: two instances (TICKS_PER_SEC 1 and 2) share one directed stimulus
// and are checked every cycle against a seconds-of-day model, plus literal expectations.
module tb_contador_hms;

  logic clk_in = 1'b0;
  logic rst;

  contador_hms_if if1 ();
  contador_hms_if if2 ();

  contador_hms #(.TICKS_PER_SEC(1)) u_dut1 (.clk_in(clk_in), .rst(rst), .bus(if1));
  contador_hms #(.TICKS_PER_SEC(2)) u_dut2 (.clk_in(clk_in), .rst(rst), .bus(if2));

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Model state per instance: time as seconds since midnight plus accepted-tick count.
  int m_secs [2];
  int m_pre  [2];
  int m_tps  [2];
  bit m_err  [2];
  bit m_sp   [2];
  bit m_mp   [2];
  bit m_dp   [2];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Decimal value of a BCD byte, or -1 when either digit is not decimal.
  function automatic int from_bcd(input logic [7:0] v);
    int hi;
    int lo;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return -1;
    return hi * 10 + lo;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_secs[i] = 0; m_pre[i] = 0; m_err[i] = 1'b0;
      m_sp[i] = 1'b0; m_mp[i] = 1'b0; m_dp[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit t, input bit r, input bit l,
                            input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
    int h, m, s;
    h = from_bcd(sh); m = from_bcd(sm); s = from_bcd(ss);
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = 1'b0; m_mp[i] = 1'b0; m_dp[i] = 1'b0;
      if (l) begin
        if (h >= 0 && h < 24 && m >= 0 && m < 60 && s >= 0 && s < 60) begin
          m_secs[i] = h * 3600 + m * 60 + s;
          m_pre[i]  = 0;
          m_err[i]  = 1'b0;
        end else begin
          m_err[i] = 1'b1;
        end
      end else if (t && r) begin
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == m_tps[i]) begin
          m_pre[i] = 0;
          m_sp[i]  = 1'b1;
          m_mp[i]  = (m_secs[i] % 60) == 59;
          m_dp[i]  = m_secs[i] == 86399;
          m_secs[i] = (m_secs[i] + 1) % 86400;
        end
      end
    end
  endtask

  task automatic read_out(input int i, output logic [7:0] h, output logic [7:0] m,
                          output logic [7:0] s, output logic sp, output logic mp,
                          output logic dp, output logic er);
    if (i == 0) begin
      h = if1.hh_bcd; m = if1.mm_bcd; s = if1.ss_bcd;
      sp = if1.sec_pulse; mp = if1.min_pulse; dp = if1.day_pulse; er = if1.load_err;
    end else begin
      h = if2.hh_bcd; m = if2.mm_bcd; s = if2.ss_bcd;
      sp = if2.sec_pulse; mp = if2.min_pulse; dp = if2.day_pulse; er = if2.load_err;
    end
  endtask

  task automatic compare_all();
    logic [7:0] h, m, s;
    logic sp, mp, dp, er;
    for (int i = 0; i < 2; i++) begin
      read_out(i, h, m, s, sp, mp, dp, er);
      chk($sformatf("u%0d hh", i + 1), int'(h), int'(to_bcd(m_secs[i] / 3600)));
      chk($sformatf("u%0d mm", i + 1), int'(m), int'(to_bcd((m_secs[i] / 60) % 60)));
      chk($sformatf("u%0d ss", i + 1), int'(s), int'(to_bcd(m_secs[i] % 60)));
      chk($sformatf("u%0d sec_pulse", i + 1), int'(sp), int'(m_sp[i]));
      chk($sformatf("u%0d min_pulse", i + 1), int'(mp), int'(m_mp[i]));
      chk($sformatf("u%0d day_pulse", i + 1), int'(dp), int'(m_dp[i]));
      chk($sformatf("u%0d load_err", i + 1), int'(er), int'(m_err[i]));
    end
  endtask

  task automatic drive(input bit t, input bit r, input bit l,
                       input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
    if1.tick_in = t; if1.run_en = r; if1.load_req = l;
    if1.set_hh = sh; if1.set_mm = sm; if1.set_ss = ss;
    if2.tick_in = t; if2.run_en = r; if2.load_req = l;
    if2.set_hh = sh; if2.set_mm = sm; if2.set_ss = ss;
  endtask

  // One clock: drive at the falling edge, predict, then check just after the rising edge.
  task automatic step(input bit t, input bit r, input bit l,
                      input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
    drive(t, r, l, sh, sm, ss);
    model_step(t, r, l, sh, sm, ss);
    @(posedge clk_in);
    #1;
    compare_all();
    @(negedge clk_in);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic load(input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
    step(1'b0, 1'b1, 1'b1, sh, sm, ss);
  endtask

  int pulses;

  initial begin
    m_tps[0] = 1;
    m_tps[1] = 2;
    model_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk_in);
    chk("reset hh", int'(if1.hh_bcd), 'h00);
    chk("reset ss", int'(if2.ss_bcd), 'h00);
    chk("reset load_err", int'(if1.load_err), 0);
    rst = 1'b0;

    // Reset then count: 4 ticks give 2 seconds at two ticks per second.
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      pulses += int'(if2.sec_pulse);
    end
    chk("tps2 ss after 4 ticks", int'(if2.ss_bcd), 'h02);
    chk("tps2 sec_pulse count", pulses, 2);
    chk("tps1 ss after 4 ticks", int'(if1.ss_bcd), 'h04);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    // Minute carry.
    load(8'h00, 8'h00, 8'h58);
    tick(1);
    chk("tps1 no min_pulse on 59", int'(if1.min_pulse), 0);
    tick(1);
    chk("tps1 mm after carry", int'(if1.mm_bcd), 'h01);
    chk("tps1 ss after carry", int'(if1.ss_bcd), 'h00);
    chk("tps1 min_pulse on carry", int'(if1.min_pulse), 1);
    chk("tps2 ss after 2 ticks", int'(if2.ss_bcd), 'h59);

    // Day wrap.
    load(8'h23, 8'h59, 8'h59);
    tick(1);
    chk("tps1 day_pulse on wrap", int'(if1.day_pulse), 1);
    chk("tps1 hh after wrap", int'(if1.hh_bcd), 'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("tps1 day_pulse one cycle", int'(if1.day_pulse), 0);

    // Invalid and valid loads.
    load(8'h24, 8'h00, 8'h00);
    chk("hh 24 rejected", int'(if1.load_err), 1);
    load(8'h12, 8'h5A, 8'h00);
    chk("mm 5A rejected", int'(if1.load_err), 1);
    load(8'h12, 8'h34, 8'h56);
    chk("valid load clears err", int'(if1.load_err), 0);
    chk("valid load hh", int'(if1.hh_bcd), 'h12);
    load(8'h00, 8'h60, 8'h00);
    load(8'h00, 8'h00, 8'h0A);

    // Load and tick together: tick dropped.
    step(1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h03);
    chk("load wins over tick", int'(if1.ss_bcd), 'h03);

    // run_en low holds everything.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("hold run_en=0", int'(if1.ss_bcd), 'h03);

    // A load clears the partial prescaler count.
    tick(1);
    load(8'h05, 8'h00, 8'h00);
    tick(1);
    chk("tps2 prescaler cleared by load", int'(if2.ss_bcd), 'h00);
    chk("tps1 after load+tick", int'(if1.ss_bcd), 'h01);

    // Hour carries 09->10 and 19->20, with long runs of back-to-back ticks.
    load(8'h09, 8'h59, 8'h58);
    tick(170);
    chk("tps1 hour 10", int'(if1.hh_bcd), 'h10);
    load(8'h19, 8'h59, 8'h59);
    tick(2);
    chk("tps1 hour 20", int'(if1.hh_bcd), 'h20);

    // Asynchronous reset between edges with a partial prescaler count pending.
    load(8'h10, 8'h20, 8'h30);
    tick(1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async rst hh", int'(if1.hh_bcd), 'h00);
    chk("async rst mm", int'(if1.mm_bcd), 'h00);
    chk("async rst ss", int'(if2.ss_bcd), 'h00);
    chk("async rst sec_pulse", int'(if1.sec_pulse), 0);
    @(negedge clk_in);
    rst = 1'b0;
    tick(1);
    chk("tps2 prescaler cleared by rst", int'(if2.ss_bcd), 'h00);
    chk("tps1 first tick after rst", int'(if1.ss_bcd), 'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/contador_hms.md
# contador_hms

Time-of-day counter that consumes the single-cycle tick strobe produced by the team's clock divider. It holds hours, minutes and seconds as packed BCD and advances one second every TICKS_PER_SEC accepted ticks. It wraps 23:59:59 to 00:00:00 and supports a validated time-load port for setting the clock. It sits between the divider and the display/decoder logic.

## Interface
- TICKS_PER_SEC, default 1: number of accepted tick_in pulses per one-second advance; legal range 1–255.
- clk_in  input  1  system clock; all registers on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- tick_in  input  1  one-cycle strobe from the clock divider; sampled on clk_in, never treated as a clock.
- run_en  input  1  1 = count ticks, 0 = hold time and prescaler.
- load_req  input  1  one-cycle request to load set_hh/set_mm/set_ss.
- set_hh  input  8  BCD hours to load, {tens, units}.
- set_mm  input  8  BCD minutes to load.
- set_ss  input  8  BCD seconds to load.
- hh_bcd  output  8  current hours, BCD, 00–23.
- mm_bcd  output  8  current minutes, BCD, 00–59.
- ss_bcd  output  8  current seconds, BCD, 00–59.
- sec_pulse  output  1  high for one cycle when seconds advance.
- min_pulse  output  1  high for one cycle when minutes advance (ss 59→00).
- day_pulse  output  1  high for one cycle on the 23:59:59→00:00:00 wrap.
- load_err  output  1  sticky flag: last load_req was rejected.

## Operation
- Reset values: hh/mm/ss = 8'h00, all pulses 0, load_err 0, prescaler 0.
- Prescaler: 8-bit counter.
  - Counts when tick_in=1, run_en=1 and load_req=0.
  - At TICKS_PER_SEC-1 it returns to 0 and issues a second advance.
  - With TICKS_PER_SEC=1, every accepted tick advances seconds.
- Second advance, with BCD carry chain:
  - ss units 9→0 carries into ss tens; ss 59→00 carries into minutes.
  - mm 59→00 carries into hours; hours count 09→10, 19→20, 23→00.
  - No digit ever holds a value above 9, and no field exceeds its maximum.
- Pulses are registered and asserted on the same edge the digits change:
  - sec_pulse on every advance.
  - min_pulse additionally when ss wraps.
  - day_pulse additionally on the full wrap.
  - All pulses are 0 on every other cycle.
- Load:
  - Valid when every nibble is ≤9, hh≤8'h23, mm≤8'h59 and ss≤8'h59.
  - A valid load writes the three fields, clears the prescaler and clears load_err.
  - An invalid load leaves time and prescaler unchanged and sets load_err.
  - load_err holds until the next valid load or reset.
  - A load generates no pulses.
- Priority: rst > load_req > tick_in. A tick_in coincident with load_req is dropped, not deferred.
- run_en=0: tick_in ignored, prescaler and time held. Loads are still honoured.

## Timing
- Latency: tick_in high at edge N → digits and pulses updated at edge N (registered outputs, visible after edge N). load_req has the same one-edge latency.
- Back-to-back ticks on consecutive cycles are each accepted; no minimum tick spacing.
- Reset mid-count or mid-load: outputs go to reset values asynchronously; the first tick after rst deasserts starts from prescaler 0.
- Pulse width is exactly one clk_in cycle, regardless of how long tick_in stays high. A tick_in held high is counted once per cycle.

## Test plan
- Reset then count, TICKS_PER_SEC=2: rst pulse, then 4 ticks → ss_bcd=8'h02; sec_pulse seen twice, each 1 cycle; hh/mm = 00.
- Minute carry, TICKS_PER_SEC=1: load 00:00:58, 2 ticks → 00:01:00; min_pulse and sec_pulse high together on the second tick only.
- Day wrap: load 23:59:59, 1 tick → 00:00:00; sec/min/day_pulse all high for one cycle.
- Invalid loads: load 24:00:00 → load_err=1, time unchanged. Load 12:5A:00 → load_err=1. Load 12:34:56 → load_err=0, time 12:34:56.
- Priority and hold:
  - load_req and tick_in in the same cycle → loaded value with no advance.
  - run_en=0 with 5 ticks → time unchanged.
  - TICKS_PER_SEC=2: one tick, then load, then one tick → no advance, because the load cleared the prescaler.
- Async reset mid-run: assert rst between clock edges at 10:20:30 → outputs 00:00:00 before the next edge; pulses 0.
